// File: rtl/mode_counter.sv
// mode_counter: up/down counter with programmable step, modulo limit MAX_VAL,
// wrap or saturate behaviour, a boundary pulse (tc), a sticky overflow flag
// (ovf) and an out-of-range load pulse (load_err). All outputs registered.
module mode_counter #(
    parameter int WIDTH   = 5,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             ovf,
    output logic             load_err
);

    // All arithmetic is done one bit wider than the counter so that sums and
    // the modulus itself (MAX_VAL+1) are representable without truncation.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0] step_x;
    logic [WIDTH:0] step_eff;
    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] wrap_up_x;
    logic [WIDTH:0] dif_x;
    logic [WIDTH:0] wrap_dn_x;

    // Fold an oversized step into range: modulo in wrap mode, clamp in saturate mode.
    always_comb begin
        step_x   = {1'b0, step};
        step_eff = step_x;
        if (step_x > MAX_X) begin
            if (sat) begin
                step_eff = MAX_X;
            end else begin
                step_eff = step_x % MOD_X;
            end
        end
    end

    // Candidate results for every direction/mode; selection happens below.
    always_comb begin
        cnt_x     = {1'b0, cnt_q};
        sum_x     = cnt_x + step_eff;
        wrap_up_x = sum_x - MOD_X;
        dif_x     = cnt_x - step_eff;
        wrap_dn_x = MOD_X - step_eff + cnt_x;
    end

    // Next-state selection: rst handled in the register, then load > enab > hold.
    always_comb begin
        cnt_d      = cnt_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        ovf_d      = ovf_q & ~clr_ovf;

        if (load) begin
            if ({1'b0, cnt_in} > MAX_X) begin
                cnt_d      = MAX_W;
                load_err_d = 1'b1;
            end else begin
                cnt_d = cnt_in;
            end
        end else if (enab && (step_eff != '0)) begin
            if (!dir) begin
                if (sum_x > MAX_X) begin
                    tc_d  = 1'b1;
                    cnt_d = sat ? MAX_W : wrap_up_x[WIDTH-1:0];
                end else begin
                    cnt_d = sum_x[WIDTH-1:0];
                end
            end else begin
                if (step_eff <= cnt_x) begin
                    cnt_d = dif_x[WIDTH-1:0];
                end else begin
                    tc_d  = 1'b1;
                    cnt_d = sat ? '0 : wrap_dn_x[WIDTH-1:0];
                end
            end
        end

        // A new boundary event wins over a simultaneous clear.
        if (tc_d) begin
            ovf_d = 1'b1;
        end
    end

    // Count and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= RST_W;
            tc_q       <= 1'b0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tc_q       <= tc_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt_out  = cnt_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against an arithmetic reference model.
module tb_mode_counter;

    localparam int W   = 5;
    localparam int MAX = 23;
    localparam int RV  = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         enab = 1'b0;
    logic         dir = 1'b0;
    logic         sat = 1'b0;
    logic [W-1:0] step = '0;
    logic [W-1:0] cnt_in = '0;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] cnt_out;
    logic         tc;
    logic         ovf;
    logic         load_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state: what the outputs must read after the next rising edge.
    int m_cnt = RV;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_err = 0;

    mode_counter #(.WIDTH(W), .MAX_VAL(MAX), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir), .sat(sat),
        .step(step), .cnt_in(cnt_in), .clr_ovf(clr_ovf),
        .cnt_out(cnt_out), .tc(tc), .ovf(ovf), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge, straight from the counting rules.
    task automatic model_edge(input int r, input int ld, input int en, input int dn,
                              input int st, input int stp, input int cin, input int clr);
        int s;
        if (r != 0) begin
            m_cnt = RV; m_tc = 0; m_ovf = 0; m_err = 0;
            return;
        end
        m_tc  = 0;
        m_err = 0;
        if (clr != 0) m_ovf = 0;
        if (ld != 0) begin
            if (cin > MAX) begin m_cnt = MAX; m_err = 1; end
            else m_cnt = cin;
        end else if (en != 0) begin
            s = stp;
            if (s > MAX) s = (st != 0) ? MAX : (s % (MAX + 1));
            if (s != 0) begin
                if (dn == 0) begin
                    if (m_cnt + s > MAX) begin
                        m_tc  = 1;
                        m_cnt = (st != 0) ? MAX : m_cnt + s - (MAX + 1);
                    end else m_cnt = m_cnt + s;
                end else begin
                    if (s <= m_cnt) m_cnt = m_cnt - s;
                    else begin
                        m_tc  = 1;
                        m_cnt = (st != 0) ? 0 : m_cnt + (MAX + 1) - s;
                    end
                end
            end
        end
        if (m_tc != 0) m_ovf = 1;
    endtask

    // Drive one transaction at the falling edge and advance the model.
    task automatic drive(input string tag, input int r, input int ld, input int en,
                         input int dn, input int st, input int stp, input int cin,
                         input int clr);
        @(negedge clk);
        rst = 1'(r); load = 1'(ld); enab = 1'(en); dir = 1'(dn); sat = 1'(st);
        step = W'(stp); cnt_in = W'(cin); clr_ovf = 1'(clr);
        model_edge(r, ld, en, dn, st, stp, cin, clr);
        chk_en = 1'b1;
        $display("%s rst=%0d load=%0d enab=%0d dir=%0d sat=%0d step=%0d cnt_in=%0d clr=%0d -> exp cnt=%0d tc=%0d ovf=%0d err=%0d",
                 tag, r, ld, en, dn, st, stp, cin, clr, m_cnt, m_tc, m_ovf, m_err);
    endtask

    // Wait until just after the edge that consumed the last driven transaction.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Every-cycle comparison against the model, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cnt_out", int'(cnt_out), m_cnt);
            chk("tc", int'(tc), m_tc);
            chk("ovf", int'(ovf), m_ovf);
            chk("load_err", int'(load_err), m_err);
        end
    end

    initial begin
        // Reset state
        drive("rst", 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("lit_rst_cnt", int'(cnt_out), 0);
        chk("lit_rst_flags", int'({tc, ovf, load_err}), 0);

        // 1: count up by 1 through the 23 -> 0 wrap
        for (int i = 1; i <= 24; i++) begin
            drive("up1", 0, 0, 1, 0, 0, 1, 0, 0);
            settle();
            chk("lit_up1_cnt", int'(cnt_out), i % 24);
            chk("lit_up1_tc", int'(tc), (i == 24) ? 1 : 0);
        end
        chk("lit_up1_ovf", int'(ovf), 1);

        // 2: up by 5 from 20, wrap then saturate
        drive("ld20", 0, 1, 0, 0, 0, 0, 20, 0);
        drive("up5w", 0, 0, 1, 0, 0, 5, 0, 0);
        settle();
        chk("lit_up5_wrap", int'(cnt_out), 1);
        chk("lit_up5_wrap_tc", int'(tc), 1);
        drive("ld20", 0, 1, 0, 0, 1, 0, 20, 0);
        drive("up5s", 0, 0, 1, 0, 1, 5, 0, 0);
        settle();
        chk("lit_up5_sat", int'(cnt_out), 23);
        chk("lit_up5_sat_tc", int'(tc), 1);
        drive("up5s", 0, 0, 1, 0, 1, 5, 0, 0);
        settle();
        chk("lit_up5_hold", int'(cnt_out), 23);
        chk("lit_up5_hold_tc", int'(tc), 1);

        // 3: down by 3 from 2, wrap then saturate
        drive("ld2", 0, 1, 0, 0, 0, 0, 2, 0);
        drive("dn3w", 0, 0, 1, 1, 0, 3, 0, 0);
        settle();
        chk("lit_dn3_wrap", int'(cnt_out), 23);
        chk("lit_dn3_wrap_tc", int'(tc), 1);
        drive("ld2", 0, 1, 0, 0, 1, 0, 2, 0);
        drive("dn3s", 0, 0, 1, 1, 1, 3, 0, 0);
        settle();
        chk("lit_dn3_sat", int'(cnt_out), 0);
        drive("dn3s", 0, 0, 1, 1, 1, 3, 0, 0);
        settle();
        chk("lit_dn3_hold", int'(cnt_out), 0);
        chk("lit_dn3_hold_tc", int'(tc), 1);

        // 4: out-of-range load, then load beating enab
        drive("ld30", 0, 1, 0, 0, 0, 0, 30, 0);
        settle();
        chk("lit_ld30_cnt", int'(cnt_out), 23);
        chk("lit_ld30_err", int'(load_err), 1);
        drive("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("lit_err_pulse", int'(load_err), 0);
        drive("ld5en", 0, 1, 1, 0, 0, 3, 5, 0);
        settle();
        chk("lit_ld_pri", int'(cnt_out), 5);
        chk("lit_ld_pri_tc", int'(tc), 0);

        // 5: clear without event, then clear racing a wrap event
        drive("clr", 0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("lit_clr_ovf", int'(ovf), 0);
        drive("ld23", 0, 1, 0, 0, 0, 0, 23, 0);
        drive("upclr", 0, 0, 1, 0, 0, 1, 0, 1);
        settle();
        chk("lit_clr_race_cnt", int'(cnt_out), 0);
        chk("lit_clr_race_ovf", int'(ovf), 1);

        // 6: reset in the middle of counting
        drive("ld16", 0, 1, 0, 0, 0, 0, 16, 0);
        drive("up1", 0, 0, 1, 0, 0, 1, 0, 0);
        settle();
        chk("lit_pre_rst", int'(cnt_out), 17);
        drive("rstmid", 1, 0, 1, 0, 0, 1, 0, 0);
        settle();
        chk("lit_mid_rst_cnt", int'(cnt_out), 0);
        chk("lit_mid_rst_flags", int'({tc, ovf, load_err}), 0);
        drive("up1", 0, 0, 1, 0, 0, 1, 0, 0);
        settle();
        chk("lit_resume", int'(cnt_out), 1);

        // Random traffic, biased toward boundary values and occasional big steps
        for (int n = 0; n < 1500; n++) begin
            int r, ld, en, dn, st, stp, cin, clr;
            r   = ($urandom_range(0, 63) == 0) ? 1 : 0;
            ld  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            dn  = int'($urandom_range(0, 1));
            st  = int'($urandom_range(0, 1));
            stp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0:       cin = int'($urandom_range(21, 31));
                1:       cin = int'($urandom_range(0, 2));
                default: cin = int'($urandom_range(0, 31));
            endcase
            clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
            drive("rnd", r, ld, en, dn, st, stp, cin, clr);
        end
        settle();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
